// File: rtl/sharpen_frame_ctrl.sv
// Frame controller for a 3x3 sharpening kernel: builds raster windows from two
// line buffers, tags kernel results through its latency and clamps them to 8 bits.
module sharpen_frame_ctrl #(
    parameter int unsigned IMG_W = 8,
    parameter int unsigned IMG_H = 8,
    parameter int unsigned KLAT  = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         cfg_we,
    input  logic [3:0]   cfg_idx,
    input  logic [7:0]   cfg_data,
    input  logic         in_valid,
    input  logic [7:0]   in_pix,
    output logic         in_ready,
    output logic [80:0]  k_img,
    output logic [71:0]  k_fil,
    input  logic [16:0]  k_out,
    output logic         out_valid,
    output logic [7:0]   out_pix,
    output logic         out_last,
    output logic         busy,
    output logic         done
);

    localparam int unsigned CW   = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int unsigned RW   = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int unsigned NTAP = 9;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2
    } state_t;

    state_t             state;
    logic [CW-1:0]      col;
    logic [RW-1:0]      row;
    logic [7:0]         buf0 [IMG_W];
    logic [7:0]         buf1 [IMG_W];
    logic [7:0]         win  [NTAP];
    logic [7:0]         coef [NTAP];
    logic               wv;
    logic               wl;
    logic [KLAT-1:0]    vsr;
    logic [KLAT-1:0]    lsr;
    logic               accept_c;
    logic               col_last_c;
    logic               row_last_c;
    logic [7:0]         clamp_c;

    assign accept_c   = in_valid && in_ready;
    assign col_last_c = (col == CW'(IMG_W - 1));
    assign row_last_c = (row == RW'(IMG_H - 1));

    function automatic logic [7:0] coef_rst(input int unsigned i);
        case (i)
            4:          coef_rst = 8'h05;
            1, 3, 5, 7: coef_rst = 8'hFF;
            default:    coef_rst = 8'h00;
        endcase
    endfunction

    // Coefficient bank; writable only while no frame is in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NTAP; i++) begin
                coef[i] <= coef_rst(i);
            end
        end else if (state == IDLE && cfg_we && cfg_idx <= 4'd8) begin
            coef[cfg_idx] <= cfg_data;
        end
    end

    // Frame sequencer
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            row      <= '0;
            col      <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= STREAM;
                        row      <= '0;
                        col      <= '0;
                        in_ready <= 1'b1;
                        busy     <= 1'b1;
                    end
                end
                STREAM: begin
                    if (accept_c) begin
                        if (col_last_c) begin
                            col <= '0;
                            if (row_last_c) begin
                                row      <= '0;
                                state    <= DRAIN;
                                in_ready <= 1'b0;
                            end else begin
                                row <= row + RW'(1);
                            end
                        end else begin
                            col <= col + CW'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (out_valid && out_last && vsr == '0 && !wv) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    in_ready <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

    // Line buffers hold the two previous rows, indexed by column
    always_ff @(posedge clk) begin
        if (accept_c) begin
            buf0[col] <= buf1[col];
            buf1[col] <= in_pix;
        end
    end

    // Window shift plus valid/last tags that travel alongside the kernel
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NTAP; i++) begin
                win[i] <= '0;
            end
            wv  <= 1'b0;
            wl  <= 1'b0;
            vsr <= '0;
            lsr <= '0;
        end else begin
            if (accept_c) begin
                for (int r = 0; r < 3; r++) begin
                    win[r*3]   <= win[r*3+1];
                    win[r*3+1] <= win[r*3+2];
                end
                win[2] <= buf0[col];
                win[5] <= buf1[col];
                win[8] <= in_pix;
            end
            wv <= accept_c && (row >= RW'(2)) && (col >= CW'(2));
            wl <= accept_c && row_last_c && col_last_c;
            vsr[0] <= wv;
            lsr[0] <= wl;
            for (int i = 1; i < KLAT; i++) begin
                vsr[i] <= vsr[i-1];
                lsr[i] <= lsr[i-1];
            end
        end
    end

    // Saturate the signed kernel sum into the 0..255 pixel range
    always_comb begin
        clamp_c = k_out[7:0];
        if (k_out[16]) begin
            clamp_c = 8'h00;
        end else if (|k_out[15:8]) begin
            clamp_c = 8'hFF;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_pix   <= '0;
        end else begin
            out_valid <= vsr[KLAT-1];
            out_last  <= lsr[KLAT-1];
            if (vsr[KLAT-1]) begin
                out_pix <= clamp_c;
            end
        end
    end

    always_comb begin
        k_img = '0;
        k_fil = '0;
        for (int i = 0; i < NTAP; i++) begin
            k_img[9*i +: 9] = {1'b0, win[i]};
            k_fil[8*i +: 8] = coef[i];
        end
    end

endmodule

// File: tb/tb_sharpen_frame_ctrl.sv
// Directed bench: a 3x3 and a 4x4 controller, each driving a behavioural
// multiply-accumulate kernel with its own latency.
module tb_sharpen_frame_ctrl;

    localparam int unsigned KLAT_A = 1;
    localparam int unsigned KLAT_B = 2;
    localparam logic [71:0] KFIL_DEF = 72'h00_FF_00_FF_05_FF_00_FF_00;
    localparam logic [71:0] KFIL_ID  = 72'h00_00_00_00_01_00_00_00_00;

    typedef struct {
        logic [7:0] pix;
        logic       last;
        int         cyc;
    } obs_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;

    logic        a_start = 0, a_cfg_we = 0, a_in_valid = 0;
    logic [3:0]  a_cfg_idx = 0;
    logic [7:0]  a_cfg_data = 0, a_in_pix = 0;
    logic        a_in_ready, a_out_valid, a_out_last, a_busy, a_done;
    logic [80:0] a_k_img;
    logic [71:0] a_k_fil;
    logic [16:0] a_k_out;
    logic [7:0]  a_out_pix;

    logic        b_start = 0, b_cfg_we = 0, b_in_valid = 0;
    logic [3:0]  b_cfg_idx = 0;
    logic [7:0]  b_cfg_data = 0, b_in_pix = 0;
    logic        b_in_ready, b_out_valid, b_out_last, b_busy, b_done;
    logic [80:0] b_k_img;
    logic [71:0] b_k_fil;
    logic [16:0] b_k_out;
    logic [7:0]  b_out_pix;

    obs_t aq[$];
    obs_t bq[$];
    int   a_ndone = 0, a_done_cyc = 0;
    int   b_ndone = 0, b_done_cyc = 0;
    logic b_busy_at_done = 1'b1;
    int   n_chk = 0, n_pass = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sharpen_frame_ctrl #(.IMG_W(3), .IMG_H(3), .KLAT(KLAT_A)) u_a (
        .clk(clk), .rst(rst), .start(a_start), .cfg_we(a_cfg_we), .cfg_idx(a_cfg_idx),
        .cfg_data(a_cfg_data), .in_valid(a_in_valid), .in_pix(a_in_pix), .in_ready(a_in_ready),
        .k_img(a_k_img), .k_fil(a_k_fil), .k_out(a_k_out), .out_valid(a_out_valid),
        .out_pix(a_out_pix), .out_last(a_out_last), .busy(a_busy), .done(a_done)
    );

    sharpen_frame_ctrl #(.IMG_W(4), .IMG_H(4), .KLAT(KLAT_B)) u_b (
        .clk(clk), .rst(rst), .start(b_start), .cfg_we(b_cfg_we), .cfg_idx(b_cfg_idx),
        .cfg_data(b_cfg_data), .in_valid(b_in_valid), .in_pix(b_in_pix), .in_ready(b_in_ready),
        .k_img(b_k_img), .k_fil(b_k_fil), .k_out(b_k_out), .out_valid(b_out_valid),
        .out_pix(b_out_pix), .out_last(b_out_last), .busy(b_busy), .done(b_done)
    );

    function automatic logic [16:0] kern(input logic [80:0] img, input logic [71:0] fil);
        int s = 0;
        for (int i = 0; i < 9; i++) begin
            s += int'(img[9*i +: 9]) * int'($signed(fil[8*i +: 8]));
        end
        return 17'(s);
    endfunction

    // Kernel models: KLAT_A and KLAT_B register stages respectively
    logic [16:0] a_kp0, b_kp0, b_kp1;
    always @(posedge clk) begin
        a_kp0 <= kern(a_k_img, a_k_fil);
        b_kp0 <= kern(b_k_img, b_k_fil);
        b_kp1 <= b_kp0;
    end
    assign a_k_out = a_kp0;
    assign b_k_out = b_kp1;

    always @(negedge clk) begin
        if (a_out_valid) aq.push_back('{a_out_pix, a_out_last, cyc});
        if (b_out_valid) bq.push_back('{b_out_pix, b_out_last, cyc});
        if (a_done) begin a_ndone++; a_done_cyc = cyc; end
        if (b_done) begin b_ndone++; b_done_cyc = cyc; b_busy_at_done = b_busy; end
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic clear_obs();
        aq.delete(); bq.delete();
        a_ndone = 0; b_ndone = 0; b_busy_at_done = 1'b1;
    endtask

    task automatic send_a(input logic [7:0] px [9], output int acc_last);
        @(negedge clk) a_start = 1'b1;
        @(negedge clk) a_start = 1'b0;
        check("a_ready", 128'(a_in_ready), 128'(1));
        for (int i = 0; i < 9; i++) begin
            a_in_valid = 1'b1; a_in_pix = px[i];
            if (i == 8) acc_last = cyc;
            @(negedge clk);
        end
        a_in_valid = 1'b0;
    endtask

    task automatic send_b(input logic [7:0] px [16], input int npix, input bit gap,
                          input bit poke_start, input bit poke_cfg, output int acc10);
        acc10 = 0;
        @(negedge clk) b_start = 1'b1;
        @(negedge clk) b_start = 1'b0;
        check("b_ready", 128'(b_in_ready), 128'(1));
        for (int i = 0; i < npix; i++) begin
            b_in_valid = 1'b1; b_in_pix = px[i];
            if (i == 10) acc10 = cyc;
            if (poke_cfg && i == 5) begin b_cfg_we = 1'b1; b_cfg_idx = 4'd4; b_cfg_data = 8'd7; end
            @(negedge clk);
            b_cfg_we = 1'b0;
            if (gap) begin
                b_in_valid = 1'b0;
                b_start = poke_start;
                @(negedge clk);
                b_start = 1'b0;
            end
        end
        b_in_valid = 1'b0;
        if (poke_start) begin
            b_start = 1'b1;
            @(negedge clk) b_start = 1'b0;
        end
    endtask

    task automatic cfg_b(input logic [3:0] idx, input logic [7:0] data);
        @(negedge clk) begin b_cfg_we = 1'b1; b_cfg_idx = idx; b_cfg_data = data; end
        @(negedge clk) b_cfg_we = 1'b0;
    endtask

    task automatic check_b4(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                            input logic [7:0] e2, input logic [7:0] e3);
        logic [7:0] ex [4];
        ex = '{e0, e1, e2, e3};
        check({tag, "_count"}, 128'(bq.size()), 128'(4));
        for (int i = 0; i < 4 && i < bq.size(); i++) begin
            check($sformatf("%s_pix%0d", tag, i), 128'(bq[i].pix), 128'(ex[i]));
            check($sformatf("%s_last%0d", tag, i), 128'(bq[i].last), 128'(i == 3));
        end
        check({tag, "_ndone"}, 128'(b_ndone), 128'(1));
        if (bq.size() == 4) check({tag, "_done_cyc"}, 128'(b_done_cyc), 128'(bq[3].cyc + 1));
        check({tag, "_busy_at_done"}, 128'(b_busy_at_done), 128'(0));
    endtask

    initial begin
        logic [7:0] pa [9];
        logic [7:0] pb [16];
        logic [7:0] pr [16];
        int acc;

        repeat (3) @(negedge clk);
        check("rst_a_ready", 128'(a_in_ready), 128'(0));
        check("rst_a_out_valid", 128'(a_out_valid), 128'(0));
        check("rst_a_out_pix", 128'(a_out_pix), 128'(0));
        check("rst_a_busy", 128'(a_busy), 128'(0));
        check("rst_a_done", 128'(a_done), 128'(0));
        check("rst_a_k_img", 128'(a_k_img), 128'(0));
        check("rst_a_k_fil", 128'(a_k_fil), 128'(KFIL_DEF));
        check("rst_b_k_fil", 128'(b_k_fil), 128'(KFIL_DEF));
        check("rst_b_out_last", 128'(b_out_last), 128'(0));
        rst = 1'b0;
        @(negedge clk);

        // 3x3: raw 1268 saturates high
        clear_obs();
        pa = '{8'd2, 8'd0, 8'd0, 8'd5, 8'd255, 8'd0, 8'd1, 8'd2, 8'd4};
        send_a(pa, acc);
        repeat (12) @(negedge clk);
        check("a1_count", 128'(aq.size()), 128'(1));
        if (aq.size() > 0) begin
            check("a1_pix", 128'(aq[0].pix), 128'(255));
            check("a1_last", 128'(aq[0].last), 128'(1));
            check("a1_lat", 128'(aq[0].cyc), 128'(acc + 2 + KLAT_A));
            check("a1_done_cyc", 128'(a_done_cyc), 128'(aq[0].cyc + 1));
        end
        check("a1_ndone", 128'(a_ndone), 128'(1));

        // 4x4 flat field passes through unchanged
        clear_obs();
        for (int i = 0; i < 16; i++) pb[i] = 8'd100;
        send_b(pb, 16, 1'b0, 1'b0, 1'b0, acc);
        repeat (15) @(negedge clk);
        check_b4("b_flat", 8'd100, 8'd100, 8'd100, 8'd100);
        check("b_flat_lat", 128'(bq.size() > 0 ? bq[0].cyc : -1), 128'(acc + 2 + KLAT_B));

        // 3x3: raw -1020 saturates low
        clear_obs();
        pa = '{8'd255, 8'd255, 8'd255, 8'd255, 8'd0, 8'd255, 8'd255, 8'd255, 8'd255};
        send_a(pa, acc);
        repeat (12) @(negedge clk);
        check("a2_count", 128'(aq.size()), 128'(1));
        if (aq.size() > 0) check("a2_pix", 128'(aq[0].pix), 128'(0));

        // Identity kernel, out-of-range index ignored, mid-frame write ignored
        clear_obs();
        for (int i = 0; i < 9; i++) cfg_b(4'(i), (i == 4) ? 8'd1 : 8'd0);
        cfg_b(4'd9, 8'h55);
        check("b_kfil_id", 128'(b_k_fil), 128'(KFIL_ID));
        for (int i = 0; i < 16; i++) pr[i] = 8'(i);
        send_b(pr, 16, 1'b0, 1'b0, 1'b1, acc);
        repeat (15) @(negedge clk);
        check_b4("b_ramp", 8'd5, 8'd6, 8'd9, 8'd10);
        check("b_kfil_after", 128'(b_k_fil), 128'(KFIL_ID));

        // Throttled input with stray start pulses while busy
        clear_obs();
        send_b(pr, 16, 1'b1, 1'b1, 1'b0, acc);
        repeat (20) @(negedge clk);
        check_b4("b_gap", 8'd5, 8'd6, 8'd9, 8'd10);
        check("b_gap_lat", 128'(bq.size() > 0 ? bq[0].cyc : -1), 128'(acc + 2 + KLAT_B));
        check("b_gap_idle_busy", 128'(b_busy), 128'(0));

        // Reset mid-frame aborts and restores default coefficients
        clear_obs();
        send_b(pb, 6, 1'b0, 1'b0, 1'b0, acc);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (15) @(negedge clk);
        check("rst_mid_outputs", 128'(bq.size()), 128'(0));
        check("rst_mid_ndone", 128'(b_ndone), 128'(0));
        check("rst_mid_busy", 128'(b_busy), 128'(0));
        check("rst_mid_ready", 128'(b_in_ready), 128'(0));
        check("rst_mid_kfil", 128'(b_k_fil), 128'(KFIL_DEF));
        send_b(pb, 16, 1'b0, 1'b0, 1'b0, acc);
        repeat (15) @(negedge clk);
        check_b4("b_after_rst", 8'd100, 8'd100, 8'd100, 8'd100);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/sharpen_frame_ctrl.md
Name: sharpen_frame_ctrl

Overview:
Frame-level controller that sequences the 3x3 sharpening kernel over a raster-scanned image.
- Accepts a pixel stream and builds 3x3 windows from two line buffers.
- Drives the kernel's img/fil inputs and tags kernel results through the kernel's fixed latency.
- Clamps each result to 8 bits and emits one output pixel per interior image position.
- Holds the 9 programmable filter coefficients. Sits between the pixel source and the output pixel sink; the kernel is instantiated beside it.

Parameters:
IMG_W, 8, image width in pixels (min 3)
IMG_H, 8, image height in pixels (min 3)
KLAT, 1, kernel latency in clocks from k_img/k_fil change to k_out valid (min 1)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
start  in  1  single-cycle pulse; begins a frame when IDLE
cfg_we  in  1  coefficient write strobe
cfg_idx  in  4  coefficient index, row*3+col, 0..8
cfg_data  in  8  signed coefficient value
in_valid  in  1  input pixel valid
in_pix  in  8  input pixel, raster order
in_ready  out  1  controller accepts pixel this cycle
k_img  out  81  window to kernel, element i=row*3+col at bits [9i+8:9i], zero-extended 9-bit
k_fil  out  72  coefficients to kernel, element i at bits [8i+7:8i], signed
k_out  in  17  signed kernel result
out_valid  out  1  output pixel valid (single-cycle)
out_pix  out  8  clamped output pixel
out_last  out  1  with out_valid: final output pixel of frame
busy  out  1  high in STREAM or DRAIN
done  out  1  single-cycle pulse at frame end

Behaviour:
- Reset:
  - State IDLE. Row/col counters, window registers and valid shift register are cleared.
  - in_ready, out_valid, out_last, busy and done are 0; out_pix is 0; k_img is 0.
  - Coefficients reset to {0,-1,0; -1,5,-1; 0,-1,0}.
- Reset mid-frame aborts the frame immediately with the same values; no done pulse.
- Coefficient writes are applied only in IDLE.
  - cfg_we with cfg_idx<=8 updates that coefficient next cycle.
  - cfg_idx>8, or any write outside IDLE, is ignored.
  - k_fil always reflects the current coefficient registers.
- States IDLE -> STREAM -> DRAIN -> IDLE:
  - IDLE: in_ready=0. start moves to STREAM next cycle. start while busy is ignored.
  - STREAM: in_ready=1. Accept = in_valid && in_ready. Col counts 0..IMG_W-1, then wraps to 0 and increments row.
  - STREAM -> DRAIN on accepting pixel (IMG_H-1, IMG_W-1).
  - DRAIN: in_ready=0. Stays until the valid shift register is empty and the final out_valid has issued.
  - DRAIN -> IDLE: done=1 in the cycle after the final out_valid, same cycle as the return to IDLE.
- Line buffers: two IMG_W-deep 8-bit buffers indexed by col, written only on accept.
  - buf1 holds row r-1 and buf0 holds row r-2 relative to the incoming row r.
  - On accept, buf0[col] <= buf1[col] and buf1[col] <= in_pix.
- Window:
  - On accept the 3x3 window registers shift left one column.
  - The new right column is {buf0[col], buf1[col], in_pix} for rows 0,1,2.
  - k_img is the registered window, updated the cycle after accept (t+1).
- Window valid: an accept at (r,c) with r>=2 and c>=2 produces a valid window centred on (r-1,c-1).
  - The valid bit enters a KLAT-deep shift register at t+1.
  - The tagged bit exits when k_out is valid (t+1+KLAT).
- Output register at t+2+KLAT:
  - out_valid=1.
  - out_pix = 0 if k_out<0; 255 if k_out>255; else k_out[7:0].
- out_last accompanies the output for centre (IMG_H-2, IMG_W-2).
- Exactly (IMG_W-2)*(IMG_H-2) outputs per frame. Columns 0/1 of each row and rows 0/1 produce none, so there is no wrap-around window.
- Gaps in in_valid stall the counters and window. In-flight valid bits still advance each cycle, since the kernel is free-running.

Test Plan:
- IMG_W=IMG_H=3, default coefs, pixels 2,0,0,5,255,0,1,2,4 -> one output: raw 1268 -> out_pix=255, out_last=1, done one cycle later.
- IMG_W=IMG_H=4, all pixels 100 -> exactly 4 outputs, each out_pix=100; out_last only on 4th; busy deasserts with done.
- 3x3 frame, centre 0 and neighbours 255 (default coefs) -> raw -1020 -> out_pix=0.
- In IDLE write coef idx4=1 and all others 0, then frame 4x4 with pixels 0..15 -> outputs 5,6,9,10. A cfg write issued mid-frame has no effect.
- 4x4 frame with in_valid toggling every other cycle -> same 4 outputs as continuous input. Latency is accept-of-(2,2) +2+KLAT; start pulses during busy are ignored.
- Assert rst after 6 pixels of a 4x4 frame -> no outputs, no done, coefs back to default. The next start runs a full clean frame.
